// File: rtl/spi_pkg.sv
// Shared types for the parametrised SPI master: FSM states and the
// per-transfer configuration shadow register.
package spi_pkg;

  localparam int unsigned CFG_DIV_W = 32;
  localparam int unsigned CFG_CS_W  = 3;

  typedef enum logic [1:0] {
    IDLE,
    LEAD,
    SHIFT,
    TRAIL
  } spi_state_t;

  typedef struct packed {
    logic                 cpol;
    logic                 cpha;
    logic                 lsb_first;
    logic [CFG_DIV_W-1:0] div;
    logic [CFG_CS_W-1:0]  cs_sel;
  } spi_cfg_t;

endpackage

// File: rtl/spi_clk_div.sv
// Loadable down-counter: one-cycle half_tick_c every div+1 cycles while en is
// high; the count reloads whenever en is low so each frame starts fresh.
module spi_clk_div #(
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             half_tick_c
);

  logic [DIV_W-1:0] cnt;

  assign half_tick_c = en && (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!en || (cnt == '0)) begin
      cnt <= div;
    end else begin
      cnt <= cnt - DIV_W'(1);
    end
  end

endmodule

// File: rtl/spi_master_gen.sv
// SPI master engine: all four CPOL/CPHA modes, runtime SCK divider,
// DATA_W-bit frames, MSB/LSB-first, CS_N active-low chip selects.
module spi_master_gen
  import spi_pkg::*;
#(
  parameter  int unsigned DATA_W = 8,
  parameter  int unsigned CS_N   = 1,
  parameter  int unsigned DIV_W  = 8,
  localparam int unsigned CSW    = (CS_N > 1) ? $clog2(CS_N) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsb_first,
  input  logic [DIV_W-1:0]  div,
  input  logic [CSW-1:0]    cs_sel,
  input  logic [DATA_W-1:0] tx_data,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              sck,
  output logic              mosi,
  input  logic              miso,
  output logic [CS_N-1:0]   cs_n
);

  localparam int unsigned EW = $clog2(2 * DATA_W) + 1;
  localparam int unsigned BW = $clog2(DATA_W) + 1;
  localparam logic [EW-1:0] EDGE_END  = EW'(2 * DATA_W);
  localparam logic [EW-1:0] EDGE_LAST = EW'(2 * DATA_W - 1);
  localparam logic [BW-1:0] BIT_END   = BW'(DATA_W);

  spi_state_t          state;
  spi_cfg_t            cfg;
  logic [DATA_W-1:0]   tx_sh;
  logic [DATA_W-1:0]   rx_sh;
  logic [EW-1:0]       edge_cnt;
  logic [BW-1:0]       bit_cnt;

  logic                half_tick_c;
  logic [CFG_DIV_W-1:0] div_mux_c;
  logic                toggle_c;
  logic                leading_c;
  logic                sample_c;
  logic                drive_c;

  // Out-of-range selects decode to all-ones, so the frame runs unselected.
  function automatic logic [CS_N-1:0] cs_decode(input logic [CFG_CS_W-1:0] sel);
    logic [CS_N-1:0] dec;
    for (int unsigned i = 0; i < CS_N; i++) begin
      dec[i] = (sel != CFG_CS_W'(i));
    end
    return dec;
  endfunction

  // While idle the divider preloads from the live input, matching the shadow.
  assign div_mux_c = (state == IDLE) ? CFG_DIV_W'(div) : cfg.div;

  spi_clk_div #(
    .DIV_W (CFG_DIV_W)
  ) u_clk_div (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (state != IDLE),
    .div         (div_mux_c),
    .half_tick_c (half_tick_c)
  );

  // Edge classification: odd toggles lead, even toggles trail.
  always_comb begin
    toggle_c = 1'b0;
    if (half_tick_c) begin
      if (state == LEAD) begin
        toggle_c = 1'b1;
      end else if ((state == SHIFT) && (edge_cnt != EDGE_END)) begin
        toggle_c = 1'b1;
      end
    end
    leading_c = ~edge_cnt[0];
    sample_c  = toggle_c && (leading_c != cfg.cpha);
    drive_c   = toggle_c && (cfg.cpha ? leading_c
                                      : (!leading_c && (edge_cnt != EDGE_LAST)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cfg      <= '0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      edge_cnt <= '0;
      bit_cnt  <= '0;
      sck      <= 1'b0;
      mosi     <= 1'b0;
      cs_n     <= '1;
      busy     <= 1'b0;
      rx_valid <= 1'b0;
      rx_data  <= '0;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        IDLE: begin
          sck  <= cpol;
          mosi <= 1'b0;
          if (start) begin
            cfg.cpol      <= cpol;
            cfg.cpha      <= cpha;
            cfg.lsb_first <= lsb_first;
            cfg.div       <= CFG_DIV_W'(div);
            cfg.cs_sel    <= CFG_CS_W'(cs_sel);
            edge_cnt      <= '0;
            bit_cnt       <= '0;
            rx_sh         <= '0;
            cs_n          <= cs_decode(CFG_CS_W'(cs_sel));
            busy          <= 1'b1;
            if (!cpha) begin
              mosi  <= lsb_first ? tx_data[0] : tx_data[DATA_W-1];
              tx_sh <= lsb_first ? (tx_data >> 1) : (tx_data << 1);
            end else begin
              tx_sh <= tx_data;
            end
            state <= LEAD;
          end
        end
        LEAD: begin
          cs_n <= cs_decode(cfg.cs_sel);
          if (half_tick_c) begin
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (half_tick_c && (edge_cnt == EDGE_END) && (bit_cnt == BIT_END)) begin
            state <= TRAIL;
          end
        end
        TRAIL: begin
          sck <= cfg.cpol;
          if (half_tick_c) begin
            cs_n     <= '1;
            busy     <= 1'b0;
            rx_data  <= rx_sh;
            rx_valid <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (toggle_c) begin
        sck      <= ~sck;
        edge_cnt <= edge_cnt + EW'(1);
      end
      if (sample_c) begin
        rx_sh   <= cfg.lsb_first ? {miso, rx_sh[DATA_W-1:1]} : {rx_sh[DATA_W-2:0], miso};
        bit_cnt <= bit_cnt + BW'(1);
      end
      if (drive_c) begin
        mosi  <= cfg.lsb_first ? tx_sh[0] : tx_sh[DATA_W-1];
        tx_sh <= cfg.lsb_first ? (tx_sh >> 1) : (tx_sh << 1);
      end
    end
  end

endmodule

// File: tb/tb_spi_master_gen.sv
// Self-checking bench for spi_master_gen: scoreboard of expected frames plus
// per-frame timing, edge, mosi-order and chip-select checks.
module tb_spi_master_gen;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CS_N   = 3;
  localparam int unsigned DIV_W  = 8;
  localparam int unsigned CSW    = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              cpol = 1'b0;
  logic              cpha = 1'b0;
  logic              lsb_first = 1'b0;
  logic [DIV_W-1:0]  div = '0;
  logic [CSW-1:0]    cs_sel = '0;
  logic [DATA_W-1:0] tx_data = '0;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              busy;
  logic              sck;
  logic              mosi;
  logic              miso;
  logic [CS_N-1:0]   cs_n;
  logic              loop_en = 1'b1;
  logic              miso_val = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  logic [DATA_W-1:0] sb[$];

  assign miso = loop_en ? mosi : miso_val;

  always #5 clk = ~clk;

  spi_master_gen #(
    .DATA_W (DATA_W),
    .CS_N   (CS_N),
    .DIV_W  (DIV_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .cpol      (cpol),
    .cpha      (cpha),
    .lsb_first (lsb_first),
    .div       (div),
    .cs_sel    (cs_sel),
    .tx_data   (tx_data),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .busy      (busy),
    .sck       (sck),
    .mosi      (mosi),
    .miso      (miso),
    .cs_n      (cs_n)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] d);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = d[7-i];
    return r;
  endfunction

  task automatic run_frame(input string tag, input logic pol, input logic pha,
                           input logic lsb, input logic [DIV_W-1:0] dv,
                           input logic [CSW-1:0] sel, input logic [DATA_W-1:0] tx,
                           input logic lp, input logic mval,
                           input logic [DATA_W-1:0] exp_rx, input logic again);
    int busy_cnt, tog, rises, vals, exp_busy;
    logic [7:0] cap;
    logic lead1, prev, done, busy_after;
    logic [CS_N-1:0] cs_seen, exp_cs;
    busy_cnt = 0; tog = 0; rises = 0; vals = 0; cap = '0; lead1 = 1'b0;
    cs_seen = '0; done = 1'b0; busy_after = 1'b0;
    exp_busy = (2 * DATA_W + 2) * (int'(dv) + 1);
    exp_cs = (int'(sel) < CS_N) ? CS_N'(1 << sel) : '0;

    @(negedge clk);
    cpol = pol; cpha = pha; lsb_first = lsb; div = dv; cs_sel = sel;
    tx_data = tx; loop_en = lp; miso_val = mval;
    @(negedge clk);
    chk({tag, "_idle_sck"}, 32'(sck), 32'(pol));
    start = 1'b1;
    sb.push_back(exp_rx);
    @(negedge clk);
    start = 1'b0;
    prev = pol;
    for (int i = 0; i < 2000 && !done; i++) begin
      start = again && (i == 4);
      if (busy) busy_cnt++;
      if (sck != prev) begin
        tog++;
        if (sck) rises++;
        if (tog == 1) lead1 = mosi;
        if (tog[0] != pha) cap = {cap[6:0], mosi};
      end
      prev = sck;
      cs_seen = cs_seen | ~cs_n;
      if (rx_valid) begin
        vals++;
        if (sb.size() == 0) chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        else chk({tag, "_rx"}, 32'(rx_data), 32'(sb.pop_front()));
      end
      if (!busy) done = 1'b1;
      else @(negedge clk);
    end
    start = 1'b0;
    chk({tag, "_timeout"}, 32'(done), 32'd1);
    repeat (3) begin
      @(negedge clk);
      if (rx_valid) vals++;
      busy_after = busy_after | busy;
    end
    chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_busy));
    chk({tag, "_toggles"}, 32'(tog), 32'(2 * DATA_W));
    chk({tag, "_rises"}, 32'(rises), 32'(DATA_W));
    chk({tag, "_mosi_seq"}, 32'(cap), 32'(lsb ? rev8(tx) : tx));
    chk({tag, "_first_bit"}, 32'(lead1), 32'(lsb ? tx[0] : tx[DATA_W-1]));
    chk({tag, "_valid_pulses"}, 32'(vals), 32'd1);
    chk({tag, "_cs_asserted"}, 32'(cs_seen), 32'(exp_cs));
    chk({tag, "_cs_after"}, 32'(cs_n), 32'({CS_N{1'b1}}));
    chk({tag, "_sck_after"}, 32'(sck), 32'(pol));
    chk({tag, "_busy_after"}, 32'(busy_after), 32'd0);
  endtask

  initial begin
    logic seen_valid;
    #12;
    chk("reset_sck", 32'(sck), 32'd0);
    chk("reset_mosi", 32'(mosi), 32'd0);
    chk("reset_cs_n", 32'(cs_n), 32'(3'b111));
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_rx_valid", 32'(rx_valid), 32'd0);
    chk("reset_rx_data", 32'(rx_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_frame("m0_a5", 1'b0, 1'b0, 1'b0, 8'd0, 2'd0, 8'hA5, 1'b1, 1'b0, 8'hA5, 1'b0);
    run_frame("m3_3c", 1'b1, 1'b1, 1'b0, 8'd3, 2'd0, 8'h3C, 1'b0, 1'b1, 8'hFF, 1'b0);
    run_frame("m1_lsb", 1'b0, 1'b1, 1'b1, 8'd0, 2'd0, 8'h01, 1'b1, 1'b0, 8'h01, 1'b0);
    run_frame("m2_c3", 1'b1, 1'b0, 1'b0, 8'd1, 2'd0, 8'hC3, 1'b1, 1'b0, 8'hC3, 1'b0);
    run_frame("restart_ign", 1'b0, 1'b0, 1'b0, 8'd0, 2'd0, 8'h96, 1'b1, 1'b0, 8'h96, 1'b1);

    // Abort a frame mid-shift with an asynchronous reset
    @(negedge clk);
    cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0; div = '0; cs_sel = '0;
    tx_data = 8'h5A; loop_en = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    chk("abort_busy_before", 32'(busy), 32'd1);
    chk("abort_cs_before", 32'(cs_n), 32'(3'b110));
    #1 rst_n = 1'b0;
    #1;
    chk("abort_cs_n", 32'(cs_n), 32'(3'b111));
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_sck", 32'(sck), 32'd0);
    chk("abort_rx_data", 32'(rx_data), 32'd0);
    seen_valid = rx_valid;
    repeat (3) begin
      @(negedge clk);
      seen_valid = seen_valid | rx_valid;
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      seen_valid = seen_valid | rx_valid;
    end
    chk("abort_no_valid", 32'(seen_valid), 32'd0);

    run_frame("post_abort", 1'b0, 1'b0, 1'b0, 8'd0, 2'd0, 8'h5A, 1'b1, 1'b0, 8'h5A, 1'b0);
    run_frame("cs_sel1", 1'b0, 1'b0, 1'b0, 8'd0, 2'd1, 8'h69, 1'b1, 1'b0, 8'h69, 1'b0);
    run_frame("cs_sel3", 1'b0, 1'b0, 1'b1, 8'd2, 2'd3, 8'hB4, 1'b1, 1'b0, 8'hB4, 1'b0);

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
